// File: rtl/uart_rx_shift.sv
// UART receive shift stage: synchronizes and oversamples rx, deframes
// start/data/parity/stop bits and strobes one push per received character.
module uart_rx_shift #(
  parameter int OVS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       rx_reset,
  input  logic       rx,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       eps,
  input  logic       sticky_parity,
  output logic [7:0] rx_data,
  output logic       push,
  output logic       pe,
  output logic       fe,
  output logic       bi,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_MARK = 3'd5
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(OVS - 1);
  localparam logic [3:0] CNT_MID  = 4'(OVS / 2 - 1);

  // Expected parity bit; unreceived data bits are zero so they never disturb the XOR.
  function automatic logic parity_expected(input logic [7:0] data,
                                           input logic       eps_v,
                                           input logic       sticky_v);
    logic r;
    if (sticky_v) begin
      r = ~eps_v;
    end else begin
      r = (^data) ^ ~eps_v;
    end
    return r;
  endfunction

  logic       rx_meta_r, rx_sync_r;
  state_t     state_r, state_s;
  logic [3:0] cnt_r, cnt_s;
  logic [3:0] nbit_r, nbit_s;
  logic [3:0] nbits_s;
  logic [7:0] shift_r, shift_s;
  logic       pe_next_r, pe_next_s;
  logic       par_bit_r, par_bit_s;
  logic [7:0] rx_data_r, rx_data_s;
  logic       push_r, push_s;
  logic       pe_r, pe_s;
  logic       fe_r, fe_s;
  logic       bi_r, bi_s;
  logic       busy_r, busy_s;

  assign nbits_s = 4'd5 + {2'b00, wls};

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Next-state, counter, shift-register and output computation.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    nbit_s    = nbit_r;
    shift_s   = shift_r;
    pe_next_s = pe_next_r;
    par_bit_s = par_bit_r;
    rx_data_s = rx_data_r;
    pe_s      = pe_r;
    fe_s      = fe_r;
    bi_s      = bi_r;
    push_s    = 1'b0;
    if (rx_reset) begin
      state_s = ST_IDLE;
      cnt_s   = 4'd0;
    end else if (baud_pulse) begin
      case (state_r)
        ST_IDLE: begin
          if (!rx_sync_r) begin
            cnt_s   = 4'd0;
            state_s = ST_START;
          end else begin
            cnt_s = 4'd0;
          end
        end
        ST_START: begin
          if (cnt_r == CNT_MID) begin
            cnt_s = 4'd0;
            if (rx_sync_r) begin
              state_s = ST_IDLE;
            end else begin
              nbit_s  = 4'd0;
              shift_s = 8'h00;
              state_s = ST_DATA;
            end
          end else begin
            cnt_s = cnt_r + 4'd1;
          end
        end
        ST_DATA: begin
          if (cnt_r == CNT_LAST) begin
            shift_s[nbit_r[2:0]] = rx_sync_r;
            cnt_s  = 4'd0;
            nbit_s = nbit_r + 4'd1;
            if ((nbit_r + 4'd1) == nbits_s) begin
              state_s = pen ? ST_PARITY : ST_STOP;
            end else begin
              state_s = ST_DATA;
            end
          end else begin
            cnt_s = cnt_r + 4'd1;
          end
        end
        ST_PARITY: begin
          if (cnt_r == CNT_LAST) begin
            par_bit_s = rx_sync_r;
            pe_next_s = rx_sync_r ^ parity_expected(shift_r, eps, sticky_parity);
            cnt_s     = 4'd0;
            state_s   = ST_STOP;
          end else begin
            cnt_s = cnt_r + 4'd1;
          end
        end
        ST_STOP: begin
          if (cnt_r == CNT_LAST) begin
            rx_data_s = shift_r;
            pe_s      = pen & pe_next_r;
            fe_s      = ~rx_sync_r;
            // Break: every bit of the frame, stop included, was a space.
            bi_s      = (shift_r == 8'h00) & ~rx_sync_r & (~pen | ~par_bit_r);
            push_s    = 1'b1;
            cnt_s     = 4'd0;
            state_s   = bi_s ? ST_WAIT_MARK : ST_IDLE;
          end else begin
            cnt_s = cnt_r + 4'd1;
          end
        end
        ST_WAIT_MARK: begin
          if (rx_sync_r) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_WAIT_MARK;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = 4'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
    busy_s = (state_s != ST_IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      nbit_r    <= 4'd0;
      shift_r   <= 8'h00;
      pe_next_r <= 1'b0;
      par_bit_r <= 1'b0;
      rx_data_r <= 8'h00;
      push_r    <= 1'b0;
      pe_r      <= 1'b0;
      fe_r      <= 1'b0;
      bi_r      <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      nbit_r    <= nbit_s;
      shift_r   <= shift_s;
      pe_next_r <= pe_next_s;
      par_bit_r <= par_bit_s;
      rx_data_r <= rx_data_s;
      push_r    <= push_s;
      pe_r      <= pe_s;
      fe_r      <= fe_s;
      bi_r      <= bi_s;
      busy_r    <= busy_s;
    end
  end

  assign rx_data = rx_data_r;
  assign push    = push_r;
  assign pe      = pe_r;
  assign fe      = fe_r;
  assign bi      = bi_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_uart_rx_shift.sv
// Directed, table-driven bench for uart_rx_shift: serial frames are driven
// bit by bit at 16 baud ticks per bit and each push is compared to hand values.
module tb_uart_rx_shift;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_pulse;
  logic       rx_reset;
  logic       rx;
  logic [1:0] wls;
  logic       pen, eps, sticky_parity;
  logic [7:0] rx_data;
  logic       push, pe, fe, bi, busy;

  int n_vec = 0;
  int n_err = 0;
  int push_cnt = 0;
  logic [7:0] cap_data;
  logic       cap_pe, cap_fe, cap_bi;
  logic [1:0] tick_div = 2'd0;

  uart_rx_shift #(.OVS(16)) dut (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .rx_reset(rx_reset), .rx(rx),
    .wls(wls), .pen(pen), .eps(eps), .sticky_parity(sticky_parity),
    .rx_data(rx_data), .push(push), .pe(pe), .fe(fe), .bi(bi), .busy(busy)
  );

  always #5 clk = ~clk;

  // One baud tick every fourth clock.
  initial begin
    baud_pulse = 1'b0;
    forever begin
      @(negedge clk);
      tick_div   = tick_div + 2'd1;
      baud_pulse = (tick_div == 2'd0);
    end
  end

  // Count pushes and capture the character each one presents.
  always @(negedge clk) begin
    if (push) begin
      push_cnt = push_cnt + 1;
      cap_data = rx_data;
      cap_pe   = pe;
      cap_fe   = fe;
      cap_bi   = bi;
    end
  end

  typedef struct {
    logic [7:0] d;
    logic [1:0] wls_v;
    logic       pen_v, eps_v, sticky_v, par, stp;
    logic [7:0] exp_data;
    logic       exp_pe, exp_fe, exp_bi;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (4 * n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic pen_b,
                            input logic par, input logic stp, input int idle_bits);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    if (pen_b) begin
      rx = par;
      wait_ticks(16);
    end
    rx = stp;
    wait_ticks(16);
    rx = 1'b1;
    wait_ticks(16 * idle_bits);
  endtask

  task automatic check_char(input string tag, input int base, input logic [7:0] ed,
                            input logic epe, input logic efe, input logic ebi);
    check({tag, ".push_count"}, 32'(push_cnt - base), 32'd1);
    check({tag, ".rx_data"}, {24'd0, cap_data}, {24'd0, ed});
    check({tag, ".pe"}, {31'd0, cap_pe}, {31'd0, epe});
    check({tag, ".fe"}, {31'd0, cap_fe}, {31'd0, efe});
    check({tag, ".bi"}, {31'd0, cap_bi}, {31'd0, ebi});
    check({tag, ".busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int base;
    //            d      wls    pen   eps   stk   par   stp   exp    pe    fe    bi
    vecs[0] = '{8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h07, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'h07, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h07, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h15, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h15, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h07, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'hEA, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h2A, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{8'h55, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};

    rst = 1'b0; rx = 1'b1; rx_reset = 1'b0;
    wls = 2'b11; pen = 1'b0; eps = 1'b0; sticky_parity = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_outputs", {18'd0, rx_data, push, pe, fe, bi, busy}, 32'd0);
    rst = 1'b1;
    wait_ticks(32);

    for (int v = 0; v < 8; v++) begin
      wls = vecs[v].wls_v; pen = vecs[v].pen_v; eps = vecs[v].eps_v;
      sticky_parity = vecs[v].sticky_v;
      base = push_cnt;
      send_frame(vecs[v].d, 5 + int'(vecs[v].wls_v), vecs[v].pen_v,
                 vecs[v].par, vecs[v].stp, 3);
      check_char($sformatf("vec%0d", v), base, vecs[v].exp_data,
                 vecs[v].exp_pe, vecs[v].exp_fe, vecs[v].exp_bi);
    end

    // Short glitch: a false start that never pushes.
    wls = 2'b11; pen = 1'b0; eps = 1'b0; sticky_parity = 1'b0;
    base = push_cnt;
    rx = 1'b0;
    wait_ticks(4);
    check("glitch.busy_high", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    wait_ticks(48);
    check("glitch.busy_low", {31'd0, busy}, 32'd0);
    check("glitch.no_push", 32'(push_cnt - base), 32'd0);

    // Held break: one character, then wait for mark before the next frame.
    base = push_cnt;
    rx = 1'b0;
    wait_ticks(16 * 30);
    check("break.busy_held", {31'd0, busy}, 32'd1);
    check("break.push_count", 32'(push_cnt - base), 32'd1);
    check("break.rx_data", {24'd0, cap_data}, 32'd0);
    check("break.fe_bi", {30'd0, cap_fe, cap_bi}, 32'd3);
    rx = 1'b1;
    wait_ticks(32);
    check("break.busy_released", {31'd0, busy}, 32'd0);
    base = push_cnt;
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 3);
    check_char("after_break", base, 8'h3C, 1'b0, 1'b0, 1'b0);

    // rx_reset in the middle of the data bits.
    base = push_cnt;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 3; i++) begin
      rx = (i == 1) ? 1'b1 : 1'b0;
      wait_ticks(16);
    end
    check("abort.busy_before", {31'd0, busy}, 32'd1);
    rx_reset = 1'b1;
    @(negedge clk);
    rx_reset = 1'b0;
    check("abort.busy_next_clk", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    wait_ticks(16 * 12);
    check("abort.no_push", 32'(push_cnt - base), 32'd0);
    base = push_cnt;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 3);
    check_char("after_abort", base, 8'h5A, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-frame clears the held character at once.
    rx = 1'b0;
    wait_ticks(40);
    rst = 1'b0;
    #1;
    check("rst_mid.outputs", {18'd0, rx_data, push, pe, fe, bi, busy}, 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_ticks(32);
    base = push_cnt;
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 3);
    check_char("after_rst", base, 8'hC3, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
